// File: rtl/sparse_encoder.sv
// sparse_encoder: turns a dense signed raster frame into a stream of (value,row,col)
// entries for the non-zero pixels. The last entry of a frame carries out_last.
// A one-entry pending register delays each entry until the next non-zero pixel
// or the end of the frame, so the final entry can be tagged before it is queued.
// Build macro SPARSE_ENC_THRESH_EN adds a 'thresh' input; pixels whose magnitude
// is <= thresh are then treated as zero.
module sparse_encoder #(
  parameter int unsigned dataRowNum       = 28,
  parameter int unsigned wordLength       = 8,
  parameter int unsigned doublewordLength = 16
) (
  input  logic                         clk,
  input  logic                         irst_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [wordLength-1:0] in_pixel,
`ifdef SPARSE_ENC_THRESH_EN
  input  logic [wordLength-1:0]        thresh,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [wordLength-1:0] out_value,
  output logic [wordLength-1:0]        out_row,
  output logic [wordLength-1:0]        out_col,
  output logic                         out_last,
  output logic [doublewordLength-1:0]  nnz_count,
  output logic                         done
);

  localparam int unsigned PendW  = 3 * wordLength;
  localparam int unsigned EntryW = PendW + 1;
  localparam logic [wordLength-1:0] LastIdx = wordLength'(dataRowNum - 1);

  typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} state_e;

  state_e                      state_q, state_d;
  logic [wordLength-1:0]       row_q, row_d, col_q, col_d;
  logic                        pend_vld_q, pend_vld_d;
  logic [PendW-1:0]            pend_q, pend_d;
  logic [doublewordLength-1:0] nnz_q, nnz_d;

  // 2-deep output FIFO, entries packed as {last, value, row, col}
  logic [EntryW-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              push, pop, fifo_free, xfer, pix_nz;
  logic [EntryW-1:0] push_entry, head;

  assign fifo_free = (cnt_q != 2'd2);
  assign in_ready  = (state_q == StScan) && fifo_free;
  assign xfer      = in_valid && in_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign nnz_count = nnz_q;

  // Stale FIFO contents are masked so idle outputs read as zero.
  assign {out_last, out_value, out_row, out_col} = out_valid ? head : '0;

`ifdef SPARSE_ENC_THRESH_EN
  logic [wordLength:0] pix_mag;
  // Magnitude one bit wider than the pixel so the most negative value maps cleanly.
  always_comb begin
    pix_mag = in_pixel[wordLength-1] ? ((wordLength + 1)'(0) - {1'b1, in_pixel})
                                     : {1'b0, in_pixel};
  end
  assign pix_nz = (pix_mag > {1'b0, thresh});
`else
  assign pix_nz = (in_pixel != '0);
`endif

  // Next-state, counter, pending-register and FIFO-push decisions.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    nnz_d      = nnz_q;
    push       = 1'b0;
    push_entry = '0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StScan;
          row_d      = '0;
          col_d      = '0;
          pend_vld_d = 1'b0;
          nnz_d      = '0;
        end
      end
      StScan: begin
        if (xfer) begin
          if (col_q == LastIdx) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (pix_nz) begin
            // The older entry is now known not to be the last one.
            if (pend_vld_q) begin
              push       = 1'b1;
              push_entry = {1'b0, pend_q};
            end
            pend_vld_d = 1'b1;
            pend_d     = {in_pixel, row_q, col_q};
          end
          if ((row_q == LastIdx) && (col_q == LastIdx)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (pend_vld_q) begin
          if (fifo_free) begin
            push       = 1'b1;
            push_entry = {1'b1, pend_q};
            pend_vld_d = 1'b0;
          end
        end else if (!out_valid) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (push) begin
      nnz_d = nnz_q + 1'b1;
    end
  end

  // Control state, scan counters, pending entry and non-zero count.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      nnz_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      nnz_q      <= nnz_d;
    end
  end

  // Output FIFO storage and pointers; push and pop may happen together.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/sparse_encoder.md
SPARSE_ENCODER -- requirements
Module: sparse_encoder

Interface
REQ-001 SHALL have parameter dataRowNum, default 28, feature map side length in pixels.
REQ-002 SHALL have parameter wordLength, default 8, pixel and coordinate width.
REQ-003 SHALL have parameter doublewordLength, default 16, non-zero count width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port irst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, one-cycle frame start pulse, honoured only in IDLE.
REQ-007 SHALL have port in_valid, input, 1, dense pixel valid.
REQ-008 SHALL have port in_ready, output, 1, encoder accepts pixel.
REQ-009 SHALL have port in_pixel, input, wordLength, signed dense pixel in raster order (row-major, col fastest).
REQ-010 SHALL have port out_valid, output, 1, sparse entry valid.
REQ-011 SHALL have port out_ready, input, 1, downstream PE accepts entry.
REQ-012 SHALL have port out_value, output, wordLength, signed non-zero value.
REQ-013 SHALL have port out_row, output, wordLength, row index of out_value.
REQ-014 SHALL have port out_col, output, wordLength, column index of out_value.
REQ-015 SHALL have port out_last, output, 1, marks final non-zero entry of the frame.
REQ-016 SHALL have port nnz_count, output, doublewordLength, number of non-zero entries emitted in the frame.
REQ-017 SHALL have port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-018 SHALL implement FSM states IDLE, SCAN, FLUSH, DONE.
REQ-019 IDLE->SCAN on start; this clears row/col counters, nnz_count, and the pending register.
REQ-020 A pixel transfers when in_valid && in_ready; in_ready = (state==SCAN) && (output FIFO has >=1 free slot).
REQ-021 Counters SHALL advance per transferred pixel: col increments; at col==dataRowNum-1, col wraps to 0 and row increments.
REQ-022 A transferred non-zero pixel SHALL go into a one-entry pending register with its (row,col); any previously pending entry is pushed to the 2-deep output FIFO with last=0.
REQ-023 Zero pixels SHALL be dropped and only advance the counters.
REQ-024 nnz_count SHALL increment by 1 on each FIFO push and hold its value from DONE until the next start.
REQ-025 Transfer of pixel (dataRowNum-1, dataRowNum-1) SHALL move SCAN->FLUSH.
REQ-026 FLUSH SHALL push the pending entry with last=1 when the FIFO has a free slot; with no pending entry, nothing is pushed.
REQ-027 FLUSH->DONE once the pending register is empty and the FIFO is drained; done=1 for exactly the DONE cycle; DONE->IDLE unconditionally.
REQ-028 out_valid = FIFO non-empty; the head entry SHALL hold stable while out_valid && !out_ready; it pops on out_valid && out_ready.
REQ-029 A FIFO push and pop in the same cycle SHALL both occur; a push with FIFO full SHALL never happen (guaranteed by REQ-020/REQ-026).
REQ-030 All-zero frame: no entries emitted, nnz_count=0, done still pulses.
REQ-031 Latency: a non-zero pixel appears at out_* no earlier than the next non-zero pixel transfer or FLUSH, i.e. at least 1 cycle after that event.
REQ-032 start outside IDLE SHALL be ignored.

Reset
REQ-033 irst_n low SHALL immediately force IDLE, empty the FIFO and pending register, and zero the counters; in_ready=0, out_valid=0, out_value=0, out_row=0, out_col=0, out_last=0, nnz_count=0, done=0.
REQ-034 Reset mid-frame SHALL discard all partial state; the next frame requires a new start.

Configuration
REQ-035 Macro SPARSE_ENC_THRESH_EN defined: adds input port thresh (wordLength, unsigned); pixels with |in_pixel| <= thresh count as zero; |-128| is treated as 128.
REQ-036 Macro undefined: no thresh port; only in_pixel==0 counts as zero.

Verification
REQ-037 dataRowNum=4, single non-zero 5 at (2,1), out_ready=1 -> exactly one entry (5,2,1,last=1), nnz_count=1, done pulse.
REQ-038 All-zero 28x28 frame -> out_valid never 1, nnz_count=0, done pulses 1 cycle after the 784th transfer.
REQ-039 dataRowNum=4, values -3 at (0,0) and 7 at (3,3), out_ready low for 10 cycles -> in_ready drops when the FIFO fills; entries are emitted in order, the last one with last=1; out_* stable while stalled.
REQ-040 irst_n asserted after 100 transfers -> all outputs 0 at once; new start frame encodes correctly from (0,0).
REQ-041 With SPARSE_ENC_THRESH_EN, thresh=2, pixels {1,-2,3,-128} -> only 3 and -128 emitted, nnz_count=2.
